arp_eth_rx: RTL
===============

# arp_eth_rx

Parametrised ARP receive parser. Accepts an Ethernet header plus an AXI-Stream payload of any width from 8 to 64 bits, and extracts the 28-byte ARP body into a registered, handshaked frame record. It also validates the ARP header and discards trailing padding. It sits between the Ethernet demux and the ARP cache/reply logic, and replaces the fixed 8-bit parsing path.

## Interface
- DATA_WIDTH, 8, payload width in bits; legal values 8, 16, 32, 64.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- s_eth_hdr_valid / s_eth_hdr_ready  in/out  1/1  Ethernet header handshake.
- s_eth_dest_mac, s_eth_src_mac  in  48  header MACs.
- s_eth_type  in  16  EtherType.
- s_eth_payload_axis_tdata  in  DATA_WIDTH  payload data; byte 0 of each beat is in tdata[7:0].
- s_eth_payload_axis_tkeep  in  KEEP_WIDTH  byte enables; contiguous from bit 0.
- s_eth_payload_axis_tvalid / tready  in/out  1/1  payload handshake.
- s_eth_payload_axis_tlast, s_eth_payload_axis_tuser  in  1  end of frame; bad-frame flag.
- m_frame_valid / m_frame_ready  out/in  1/1  parsed frame handshake.
- m_eth_dest_mac, m_eth_src_mac  out  48  copied from the header.
- m_eth_type  out  16  copied from the header.
- m_arp_htype, m_arp_ptype, m_arp_oper  out  16  ARP fields, big-endian.
- m_arp_hlen, m_arp_plen  out  8  ARP fields.
- m_arp_sha, m_arp_tha  out  48  sender/target MAC.
- m_arp_spa, m_arp_tpa  out  32  sender/target IP.
- busy  out  1  high while a frame is being parsed.
- error_header_early_termination  out  1  one-cycle pulse: tlast arrived before 28 bytes.
- error_invalid_header  out  1  one-cycle pulse: header field check failed.

## Operation
- FSM states: IDLE, READ, DISCARD.
- IDLE:
  - s_eth_hdr_ready=1.
  - On a header handshake: latch the MACs and type, clear the byte pointer ptr (5 bits, 0..28), go to READ.
- READ:
  - Each accepted beat writes lane k (tkeep[k]=1) to ARP byte ptr+k if ptr+k<28.
  - ptr advances by popcount(tkeep), saturating at 28.
- Beat containing tlast:
  - ptr_next<28: pulse error_header_early_termination, drop the frame, go to IDLE.
  - tuser=1 on any beat of the frame: drop silently (no error pulse), go to IDLE.
  - Otherwise run the header check. Pass requires eth_type=0x0806, htype=0x0001, ptype=0x0800, hlen=6, plen=4.
  - Check fails: pulse error_invalid_header, drop.
  - Check passes: load the output register, go to IDLE.
- ptr reaches 28 without tlast: go to DISCARD. DISCARD consumes beats until tlast, then completes with the same rules as above (padding frames are legal).
- Field mapping (byte offsets): htype 0-1, ptype 2-3, hlen 4, plen 5, oper 6-7, sha 8-13, spa 14-17, tha 18-23, tpa 24-27. Byte 0 is the MSB of each multi-byte field.
- Output register:
  - m_frame_valid is held until m_frame_ready.
  - The output fields must not change while m_frame_valid=1.
- Overlap:
  - A new header may be accepted while the previous frame waits at the output.
  - In READ/DISCARD, tready = !(m_frame_valid && !m_frame_ready). This stalls the whole payload while the output is occupied.
- busy = (state != IDLE).

## Timing
- Reset values:
  - State IDLE.
  - s_eth_hdr_ready=0 during reset, 1 in the first cycle after reset.
  - tready=0, m_frame_valid=0, both error pulses 0, busy=0, all output fields 0.
- s_eth_hdr_ready and tready are registered.
- s_eth_hdr_ready drops the cycle after a header handshake. It returns the cycle after the tlast beat is accepted.
- Latency: m_frame_valid rises in the cycle after the tlast beat is accepted.
- Back-to-back: a new header may be accepted in the cycle after tlast.
- Error pulses are registered and occur in the same cycle m_frame_valid would have risen.
- Simultaneous m_frame_ready and a new completion: the old frame leaves and the new frame loads in the same edge, with no bubble.
- A tlast beat with tkeep=0 counts zero bytes.
- Reset mid-frame: all state is cleared immediately. The bench restarts on a frame boundary.

## Structure
- Shared package arp_pkg, containing:
  - ARP_LEN=28, ETHERTYPE_ARP=16'h0806, ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_OPER_REQUEST=1, ARP_OPER_REPLY=2.
  - Packed struct arp_frame_t holding the output fields.
- No sub-module. The lane-capture loop, popcount and FSM all live in arp_eth_rx.

## Test plan
- DATA_WIDTH=8, request frame with sha 5A:51:52:53:54:55, spa C0.A8.01.64, tpa C0.A8.01.65, 28 bytes, tlast on byte 27 -> m_frame_valid 1 cycle later; oper=0x0001; tha=0; m_eth_dest_mac=FFFFFFFFFFFF.
- DATA_WIDTH=64, same frame in 4 beats, last tkeep=0x0F -> identical fields. Repeat with 46-byte padded frame -> DISCARD path, same output.
- tlast at byte 20 -> error_header_early_termination single pulse, no m_frame_valid, s_eth_hdr_ready=1 the next cycle.
- hlen=8 or s_eth_type=0x0800 -> error_invalid_header pulse, no frame.
- tuser=1 on the last beat -> no frame and no error pulse.
- m_frame_ready=0 with two back-to-back frames -> second payload stalled (tready=0) until the first is taken; both frames delivered in order, fields unchanged while held.

Source files
------------

// File: rtl/arp_pkg.sv
// Shared ARP definitions: protocol constants, parser states, the parsed frame
// record and helpers that turn the captured 28-byte body into that record.
package arp_pkg;

  localparam int          ARP_LEN          = 28;
  localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DISCARD
  } arp_state_t;

  typedef struct packed {
    logic [47:0] ethDestMac;
    logic [47:0] ethSrcMac;
    logic [15:0] ethType;
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_frame_t;

  // Body byte i lives at body[i*8 +: 8]; byte 0 of a field is its MSB.
  function automatic arp_frame_t buildFrame(input logic [ARP_LEN*8-1:0] body,
                                            input logic [47:0] destMac,
                                            input logic [47:0] srcMac,
                                            input logic [15:0] ethType);
    arp_frame_t f;
    f = '0;
    f.ethDestMac = destMac;
    f.ethSrcMac  = srcMac;
    f.ethType    = ethType;
    f.htype      = {body[7:0], body[15:8]};
    f.ptype      = {body[23:16], body[31:24]};
    f.hlen       = body[39:32];
    f.plen       = body[47:40];
    f.oper       = {body[55:48], body[63:56]};
    for (int i = 0; i < 6; i++) begin
      f.sha = {f.sha[39:0], body[(8 + i)*8 +: 8]};
      f.tha = {f.tha[39:0], body[(18 + i)*8 +: 8]};
    end
    for (int i = 0; i < 4; i++) begin
      f.spa = {f.spa[23:0], body[(14 + i)*8 +: 8]};
      f.tpa = {f.tpa[23:0], body[(24 + i)*8 +: 8]};
    end
    return f;
  endfunction

  // Only Ethernet/IPv4 ARP is accepted by the downstream cache.
  function automatic logic headerOk(input arp_frame_t f);
    return (f.ethType == ETHERTYPE_ARP) && (f.htype == ARP_HTYPE_ETH) &&
           (f.ptype == ARP_PTYPE_IPV4) && (f.hlen == 8'd6) && (f.plen == 8'd4);
  endfunction

endpackage

// File: rtl/arp_eth_rx.sv
// ARP receive parser: captures the 28-byte ARP body from a payload stream of
// any byte-multiple width, validates it and presents a held output record.
module arp_eth_rx
  import arp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic                  m_frame_valid,
  input  logic                  m_frame_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [15:0]           m_arp_htype,
  output logic [15:0]           m_arp_ptype,
  output logic [7:0]            m_arp_hlen,
  output logic [7:0]            m_arp_plen,
  output logic [15:0]           m_arp_oper,
  output logic [47:0]           m_arp_sha,
  output logic [31:0]           m_arp_spa,
  output logic [47:0]           m_arp_tha,
  output logic [31:0]           m_arp_tpa,
  output logic                  busy,
  output logic                  error_header_early_termination,
  output logic                  error_invalid_header
);

  localparam logic [4:0] PTR_FULL = 5'(ARP_LEN);

  arp_state_t           state_q, state_d;
  logic [4:0]           ptr_q, ptr_d;
  logic [ARP_LEN*8-1:0] body_q, body_d;
  logic                 frameBad_q, frameBad_d;
  logic [47:0]          destMac_q, destMac_d;
  logic [47:0]          srcMac_q, srcMac_d;
  logic [15:0]          ethType_q, ethType_d;
  arp_frame_t           frame_q, frame_d, built;
  logic                 frameValid_q, frameValid_d;
  logic                 hdrReady_q, hdrReady_d;
  logic                 tready_q, tready_d;
  logic                 errEarly_q, errEarly_d;
  logic                 errInvalid_q, errInvalid_d;
  logic                 beatFire, finish;
  logic [3:0]           keepCount;
  logic [5:0]           ptrSum;

  assign beatFire = s_eth_payload_axis_tvalid && tready_q;

  // Next-state logic: header latch, lane capture, completion checks and the
  // output record, whose load takes priority over a simultaneous drain.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    body_d       = body_q;
    frameBad_d   = frameBad_q;
    destMac_d    = destMac_q;
    srcMac_d     = srcMac_q;
    ethType_d    = ethType_q;
    frame_d      = frame_q;
    frameValid_d = frameValid_q;
    errEarly_d   = 1'b0;
    errInvalid_d = 1'b0;
    finish       = 1'b0;
    keepCount    = '0;
    ptrSum       = '0;
    built        = frame_q;

    if (frameValid_q && m_frame_ready) begin
      frameValid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (s_eth_hdr_valid && hdrReady_q) begin
          destMac_d  = s_eth_dest_mac;
          srcMac_d   = s_eth_src_mac;
          ethType_d  = s_eth_type;
          ptr_d      = '0;
          frameBad_d = 1'b0;
          state_d    = READ;
        end
      end
      READ: begin
        if (beatFire) begin
          for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (s_eth_payload_axis_tkeep[k]) begin
              keepCount = keepCount + 4'd1;
              if ((int'(ptr_q) + k) < ARP_LEN) begin
                body_d[(int'(ptr_q) + k)*8 +: 8] = s_eth_payload_axis_tdata[k*8 +: 8];
              end
            end
          end
          ptrSum     = {1'b0, ptr_q} + {2'b00, keepCount};
          ptr_d      = (ptrSum >= {1'b0, PTR_FULL}) ? PTR_FULL : ptrSum[4:0];
          frameBad_d = frameBad_q | s_eth_payload_axis_tuser;
          if (s_eth_payload_axis_tlast) begin
            if (ptr_d < PTR_FULL) begin
              errEarly_d = 1'b1;
              state_d    = IDLE;
            end else begin
              finish = 1'b1;
            end
          end else if (ptr_d == PTR_FULL) begin
            state_d = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (beatFire) begin
          frameBad_d = frameBad_q | s_eth_payload_axis_tuser;
          if (s_eth_payload_axis_tlast) begin
            finish = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish) begin
      state_d = IDLE;
      built   = buildFrame(body_d, destMac_q, srcMac_q, ethType_q);
      if (!frameBad_d) begin
        if (headerOk(built)) begin
          frame_d      = built;
          frameValid_d = 1'b1;
        end else begin
          errInvalid_d = 1'b1;
        end
      end
    end

    hdrReady_d = (state_d == IDLE);
    tready_d   = (state_d != IDLE) && !frameValid_d;
  end

  // State and output registers, all cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      body_q       <= '0;
      frameBad_q   <= 1'b0;
      destMac_q    <= '0;
      srcMac_q     <= '0;
      ethType_q    <= '0;
      frame_q      <= '0;
      frameValid_q <= 1'b0;
      hdrReady_q   <= 1'b0;
      tready_q     <= 1'b0;
      errEarly_q   <= 1'b0;
      errInvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      body_q       <= body_d;
      frameBad_q   <= frameBad_d;
      destMac_q    <= destMac_d;
      srcMac_q     <= srcMac_d;
      ethType_q    <= ethType_d;
      frame_q      <= frame_d;
      frameValid_q <= frameValid_d;
      hdrReady_q   <= hdrReady_d;
      tready_q     <= tready_d;
      errEarly_q   <= errEarly_d;
      errInvalid_q <= errInvalid_d;
    end
  end

  assign s_eth_hdr_ready                = hdrReady_q;
  assign s_eth_payload_axis_tready      = tready_q;
  assign m_frame_valid                  = frameValid_q;
  assign m_eth_dest_mac                 = frame_q.ethDestMac;
  assign m_eth_src_mac                  = frame_q.ethSrcMac;
  assign m_eth_type                     = frame_q.ethType;
  assign m_arp_htype                    = frame_q.htype;
  assign m_arp_ptype                    = frame_q.ptype;
  assign m_arp_hlen                     = frame_q.hlen;
  assign m_arp_plen                     = frame_q.plen;
  assign m_arp_oper                     = frame_q.oper;
  assign m_arp_sha                      = frame_q.sha;
  assign m_arp_spa                      = frame_q.spa;
  assign m_arp_tha                      = frame_q.tha;
  assign m_arp_tpa                      = frame_q.tpa;
  assign busy                           = (state_q != IDLE);
  assign error_header_early_termination = errEarly_q;
  assign error_invalid_header           = errInvalid_q;

endmodule
